reg_rw_master: RTL and testbench
================================

Name: reg_rw_master

Overview:
Request sequencer that sits directly upstream of the 32-bit read/write storage register and drives its din/wen/ren inputs. It accepts read and write requests from a valid/ready request channel into a small in-order FIFO. It executes each request against the register with a fixed enable timing. For reads, it captures the register's dout and returns it on a valid/ready response channel.

Parameters:
DW, 32, data width of request, register and response data
DEPTH, 4, request FIFO entries; power of 2, minimum 2
RD_WAIT, 1, extra cycles reg_ren is held before reg_dout is sampled; minimum 0

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  FIFO can accept; equals !fifo_full
req_write  input  1  1 = write, 0 = read
req_wdata  input  DW  write data; ignored for reads
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DW  captured read data
reg_din  output  DW  data to register
reg_wen  output  1  register write enable
reg_ren  output  1  register read enable
reg_dout  input  DW  register output; high-Z when reg_ren = 0
busy  output  1  state != IDLE or FIFO not empty

Behaviour:
- Reset: clk and reset are fixed as one clock with a synchronous, active-high reset. At a rising edge with reset = 1:
  - FIFO emptied; state set to IDLE; wait counter cleared.
  - reg_din, reg_wen, reg_ren, rsp_valid, rsp_rdata and busy all 0; req_ready = 1 the following cycle.
  - reset overrides every other event in the same cycle.
- Reset mid-operation: any in-flight or buffered request is discarded, with no response. reg_wen and reg_ren are low in the cycle after the reset edge.
- Push: an entry {write, wdata} is written at an edge where req_valid & req_ready.
- req_ready depends only on full. A simultaneous pop does not admit a push into a full FIFO.
- Pop: happens only from IDLE when the FIFO is non-empty. Ordering is strict FIFO.
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - FIFO empty: stay in IDLE.
  - FIFO non-empty: pop the head. If write, go to WR; if read, go to RD with the wait counter = RD_WAIT.
- WR:
  - reg_wen = 1 and reg_din = popped wdata for exactly one cycle; then go to IDLE.
  - No response is generated for writes.
  - reg_din holds its last value outside WR.
- RD:
  - reg_ren = 1 for every RD cycle.
  - While counter != 0, decrement it.
  - When counter = 0, register reg_dout into rsp_rdata and go to RESP.
  - reg_ren is high for exactly RD_WAIT+1 consecutive cycles.
- RESP:
  - reg_ren = 0 and rsp_valid = 1.
  - rsp_valid & rsp_ready at an edge: go to IDLE; rsp_valid is 0 the next cycle.
  - rsp_valid must not drop without a handshake.
  - rsp_rdata stays stable while rsp_valid = 1 and holds until the next capture.
- reg_wen and reg_ren are never high in the same cycle.
- Timing: outputs are registered, or decoded from the state register only; no combinational path from req_* or rsp_ready to reg_*.
- Write latency: push at edge E0, pop at E1, reg_wen high during cycle E1–E2, register updated at E2.
- Read latency: push at E0, pop at E1, reg_ren high E1 to E(2+RD_WAIT), capture at E(2+RD_WAIT), rsp_valid high from there.
- Back-to-back requests: at least one IDLE cycle separates consecutive operations.
- Capacity: at most DEPTH buffered requests plus one in flight.
- Width rule: data passes through unmodified; no arithmetic on data. The counter width is clog2(RD_WAIT+1), minimum 1.

Test Plan:
1. Hold reset = 1 for 2 cycles, then release -> reg_wen = reg_ren = rsp_valid = busy = 0, reg_din = 0, rsp_rdata = 0, req_ready = 1.
2. Write 0x0000FFFF, then read, with rsp_ready = 1 -> reg_wen high for exactly 1 cycle with reg_din = 0x0000FFFF; rsp_rdata = 0x0000FFFF with one rsp_valid pulse.
3. Write 0xAAAA5555, write 0x12345678, then read -> two separated reg_wen pulses; response 0x12345678.
4. DEPTH = 4, rsp_ready = 0, push reads continuously -> exactly 5 accepted, then req_ready = 0. Raising rsp_ready drains all 5 responses in order.
5. RD_WAIT = 3 read -> reg_ren high for exactly 4 cycles; rsp_valid rises on the cycle after reg_ren falls.
6. Assert reset during the 2nd RD cycle with 2 requests queued -> next cycle reg_ren = 0, rsp_valid = 0, busy = 0, and no response is ever issued.

Source files
------------

// File: rtl/reg_rw_master.sv
// Request sequencer for a 32-bit read/write storage register: buffers requests in an
// in-order FIFO, drives din/wen/ren with fixed timing and returns read data on a response channel.
module reg_rw_master #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int RD_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [DW-1:0] reg_din,
  output logic          reg_wen,
  output logic          reg_ren,
  input  logic [DW-1:0] reg_dout,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RD_WAIT < 1) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW:0]     fifo_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic            empty, full, push, pop;
  logic [DW:0]     head;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = req_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = fifo_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q[AW-1:0]] <= {req_write, req_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head[DW]) begin
            state_d = WR;
            din_d   = head[DW-1:0];
          end else begin
            state_d = RD;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WR: state_d = IDLE;
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          rdata_d = reg_dout;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables and response valid decode straight from the state register.
  assign req_ready = !full;
  assign reg_wen   = (state_q == WR);
  assign reg_ren   = (state_q == RD);
  assign rsp_valid = (state_q == RESP);
  assign reg_din   = din_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_reg_rw_master.sv
// Directed bench for reg_rw_master: one instance with RD_WAIT=1, one with RD_WAIT=3,
// each attached to a behavioural storage register.
module tb_reg_rw_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, reg_wen, reg_ren, busy;
  logic [31:0] rsp_rdata, reg_din, reg_dout;
  logic [31:0] mem = '0;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b0;
  logic [31:0] b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_reg_wen, b_reg_ren, b_busy;
  logic [31:0] b_rsp_rdata, b_reg_din, b_reg_dout;
  logic [31:0] b_mem = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_rw_master #(.DW(32), .DEPTH(4), .RD_WAIT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .reg_din(reg_din), .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_dout(reg_dout),
    .busy(busy)
  );

  reg_rw_master #(.DW(32), .DEPTH(4), .RD_WAIT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .reg_din(b_reg_din), .reg_wen(b_reg_wen), .reg_ren(b_reg_ren), .reg_dout(b_reg_dout),
    .busy(b_busy)
  );

  // Storage register; junk pattern on dout when not being read exposes mistimed sampling.
  always @(posedge clk) if (reg_wen) mem <= reg_din;
  always @(posedge clk) if (b_reg_wen) b_mem <= b_reg_din;
  assign reg_dout   = reg_ren   ? mem   : 32'hDEADBEEF;
  assign b_reg_dout = b_reg_ren ? b_mem : 32'hDEADBEEF;

  logic [31:0] wen_q[$];
  logic [31:0] rsp_q[$];
  int wen_adj = 0, both_cnt = 0, rspv_cyc = 0, acc_cnt = 0;
  int ren_run = 0, last_run = 0;
  logic wen_prev = 1'b0, ren_prev = 1'b0;
  int b_ren_run = 0, b_last_run = 0, b_rsp_cnt = 0;
  logic b_ren_prev = 1'b0, b_fall_rspv = 1'b0;
  logic [31:0] b_rsp_data = '0;

  always @(posedge clk) begin
    if (reg_wen) begin
      wen_q.push_back(reg_din);
      if (wen_prev) wen_adj++;
    end
    wen_prev = reg_wen;
    if (reg_wen && reg_ren) both_cnt++;
    if (rsp_valid) rspv_cyc++;
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
    if (req_valid && req_ready) acc_cnt++;
    if (reg_ren) ren_run++;
    else if (ren_prev) begin
      last_run = ren_run;
      ren_run  = 0;
    end
    ren_prev = reg_ren;
  end

  always @(posedge clk) begin
    if (b_reg_ren) b_ren_run++;
    else if (b_ren_prev) begin
      b_last_run  = b_ren_run;
      b_ren_run   = 0;
      b_fall_rspv = b_rsp_valid;
    end
    b_ren_prev = b_reg_ren;
    if (b_rsp_valid && b_rsp_ready) begin
      b_rsp_cnt++;
      b_rsp_data = b_rsp_rdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_timeout", 32'(n < 100), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset held for two edges
    tick();
    tick();
    reset = 1'b0;
    chk("rst_wen", {31'd0, reg_wen}, 32'd0);
    chk("rst_ren", {31'd0, reg_ren}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_din", reg_din, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // Write then read with exact cycle timing
    wen_q.delete(); rsp_q.delete(); rspv_cyc = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0000FFFF;
    tick();
    req_write = 1'b0; req_wdata = 32'h0;
    chk("t2_e0_wen", {31'd0, reg_wen}, 32'd0);
    chk("t2_e0_busy", {31'd0, busy}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("t2_e1_wen", {31'd0, reg_wen}, 32'd1);
    chk("t2_e1_din", reg_din, 32'h0000FFFF);
    tick();
    chk("t2_e2_wen", {31'd0, reg_wen}, 32'd0);
    chk("t2_e2_ren", {31'd0, reg_ren}, 32'd0);
    chk("t2_e2_din_hold", reg_din, 32'h0000FFFF);
    tick();
    chk("t2_e3_ren", {31'd0, reg_ren}, 32'd1);
    tick();
    chk("t2_e4_ren", {31'd0, reg_ren}, 32'd1);
    chk("t2_e4_rspv", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("t2_e5_ren", {31'd0, reg_ren}, 32'd0);
    chk("t2_e5_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("t2_e5_rdata", rsp_rdata, 32'h0000FFFF);
    tick();
    chk("t2_e6_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("t2_e6_rdata_hold", rsp_rdata, 32'h0000FFFF);
    wait_idle();
    chk("t2_wen_pulses", wen_q.size(), 32'd1);
    chk("t2_rsp_count", rsp_q.size(), 32'd1);
    chk("t2_rspv_cycles", rspv_cyc, 32'd1);
    chk("t2_ren_run", last_run, 32'd2);

    // Two writes then a read
    wen_q.delete(); rsp_q.delete(); wen_adj = 0;
    push(1'b1, 32'hAAAA5555);
    push(1'b1, 32'h12345678);
    push(1'b0, 32'h0);
    wait_idle();
    chk("t3_wen_pulses", wen_q.size(), 32'd2);
    chk("t3_wen0", wen_q[0], 32'hAAAA5555);
    chk("t3_wen1", wen_q[1], 32'h12345678);
    chk("t3_wen_separated", wen_adj, 32'd0);
    chk("t3_rsp_count", rsp_q.size(), 32'd1);
    chk("t3_rsp_data", rsp_q[0], 32'h12345678);

    // Capacity: DEPTH buffered plus one in flight
    rsp_ready = 1'b0; acc_cnt = 0; rsp_q.delete();
    req_valid = 1'b1; req_write = 1'b0;
    repeat (12) tick();
    chk("t4_accepted", acc_cnt, 32'd5);
    chk("t4_ready_low", {31'd0, req_ready}, 32'd0);
    chk("t4_rspv_held", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk("t4_rsp_count", rsp_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t4_rsp%0d", i), rsp_q[i], 32'h12345678);
    chk("t4_ready_back", {31'd0, req_ready}, 32'd1);

    // RD_WAIT=3 instance
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_wdata = 32'h5A5AA5A5;
    tick();
    b_req_write = 1'b0;
    tick();
    b_req_valid = 1'b0;
    for (int n = 0; n < 30 && b_busy; n++) tick();
    chk("t5_idle", {31'd0, b_busy}, 32'd0);
    chk("t5_ren_run", b_last_run, 32'd4);
    chk("t5_rspv_after_fall", {31'd0, b_fall_rspv}, 32'd1);
    chk("t5_rsp_count", b_rsp_cnt, 32'd1);
    chk("t5_rsp_data", b_rsp_data, 32'h5A5AA5A5);

    // Reset during the second RD cycle with two requests queued
    rsp_q.delete(); rspv_cyc = 0; both_cnt = 0;
    req_valid = 1'b1; req_write = 1'b0;
    tick();
    tick();
    chk("t6_rd1_ren", {31'd0, reg_ren}, 32'd1);
    tick();
    chk("t6_rd2_ren", {31'd0, reg_ren}, 32'd1);
    chk("t6_queued_busy", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ren", {31'd0, reg_ren}, 32'd0);
    chk("t6_wen", {31'd0, reg_wen}, 32'd0);
    chk("t6_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    chk("t6_no_rsp", rsp_q.size(), 32'd0);
    chk("t6_no_rspv", rspv_cyc, 32'd0);
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_ren_quiet", {31'd0, reg_ren}, 32'd0);
    chk("wen_ren_overlap", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
